coin_payout: RTL and testbench

COIN_PAYOUT -- requirements
Module: coin_payout

---
 rtl/coin_payout.sv | 155 +++++++++++++++
 tb/tb_coin_payout.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/coin_payout.sv
// Coin payout controller: greedy quarter/dime/nickel ejection with a fixed idle gap between pulses.
// Optional coin inventory tracking is compiled in when COIN_INVENTORY_EN is defined.
module coin_payout #(
    parameter int unsigned GAP = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [5:0] amount,
    input  logic       load_inv,
    input  logic [3:0] inv_q,
    input  logic [3:0] inv_d,
    input  logic [3:0] inv_n,
    output logic       quarter,
    output logic       dime,
    output logic       nickel,
    output logic       busy,
    output logic       done,
    output logic       short,
    output logic [5:0] remaining
);

    // state  | meaning
    // IDLE   | waiting for start / load_inv
    // SELECT | pick largest affordable, available coin
    // PULSE  | coin output high for this one cycle
    // WAIT   | GAP idle cycles between coins
    // DONE   | issue done, latch short, back to IDLE
    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_PULSE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [3:0] GAP_M1 = 4'(GAP - 1);

    state_t     state;
    logic [3:0] gap_cnt;
    logic       have_q;
    logic       have_d;
    logic       have_n;

`ifdef COIN_INVENTORY_EN
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic [3:0] cnt_n;
    logic       short_q;

    assign have_q = (cnt_q != 4'd0);
    assign have_d = (cnt_d != 4'd0);
    assign have_n = (cnt_n != 4'd0);
    assign short  = short_q;
`else
    logic unused_inv;

    assign have_q     = 1'b1;
    assign have_d     = 1'b1;
    assign have_n     = 1'b1;
    assign short      = 1'b0;
    assign unused_inv = ^{load_inv, inv_q, inv_d, inv_n};
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            quarter   <= 1'b0;
            dime      <= 1'b0;
            nickel    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            remaining <= 6'd0;
            gap_cnt   <= 4'd0;
`ifdef COIN_INVENTORY_EN
            cnt_q     <= 4'd0;
            cnt_d     <= 4'd0;
            cnt_n     <= 4'd0;
            short_q   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
`ifdef COIN_INVENTORY_EN
                    if (load_inv) begin
                        cnt_q <= inv_q;
                        cnt_d <= inv_d;
                        cnt_n <= inv_n;
                    end
`endif
                    if (start) begin
                        remaining <= amount;
                        busy      <= 1'b1;
                        state     <= S_SELECT;
`ifdef COIN_INVENTORY_EN
                        short_q   <= 1'b0;
`endif
                    end
                end
                S_SELECT: begin
                    // comparisons guard every subtraction, so remaining cannot wrap
                    if (remaining >= 6'd25 && have_q) begin
                        quarter   <= 1'b1;
                        remaining <= remaining - 6'd25;
`ifdef COIN_INVENTORY_EN
                        cnt_q     <= cnt_q - 4'd1;
`endif
                        state     <= S_PULSE;
                    end else if (remaining >= 6'd10 && have_d) begin
                        dime      <= 1'b1;
                        remaining <= remaining - 6'd10;
`ifdef COIN_INVENTORY_EN
                        cnt_d     <= cnt_d - 4'd1;
`endif
                        state     <= S_PULSE;
                    end else if (remaining >= 6'd5 && have_n) begin
                        nickel    <= 1'b1;
                        remaining <= remaining - 6'd5;
`ifdef COIN_INVENTORY_EN
                        cnt_n     <= cnt_n - 4'd1;
`endif
                        state     <= S_PULSE;
                    end else begin
                        state <= S_DONE;
                    end
                end
                S_PULSE: begin
                    quarter <= 1'b0;
                    dime    <= 1'b0;
                    nickel  <= 1'b0;
                    gap_cnt <= GAP_M1;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (gap_cnt == 4'd0) begin
                        state <= S_SELECT;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
`ifdef COIN_INVENTORY_EN
                    short_q <= (remaining >= 6'd5);
`endif
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_coin_payout.sv
// Directed bench for coin_payout: a greedy payout model pushes expected coin/done events,
// a negedge monitor pops and compares them as the DUT emits pulses.
module tb_coin_payout;

    localparam int GAP = 2;
    localparam int PER = GAP + 2;
`ifdef COIN_INVENTORY_EN
    localparam bit INV = 1'b1;
`else
    localparam bit INV = 1'b0;
`endif

    localparam logic [3:0] K_Q = 4'b1000;
    localparam logic [3:0] K_D = 4'b0100;
    localparam logic [3:0] K_N = 4'b0010;
    localparam logic [3:0] K_DONE = 4'b0001;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [5:0] amount = 6'd0;
    logic       load_inv = 1'b0;
    logic [3:0] inv_q = 4'd0;
    logic [3:0] inv_d = 4'd0;
    logic [3:0] inv_n = 4'd0;
    logic       quarter, dime, nickel, busy, done, short;
    logic [5:0] remaining;

    typedef struct {
        logic [3:0] kind;
        int         cyc;
        logic [5:0] rem;
        logic       shrt;
    } ev_t;

    ev_t exp_q[$];
    int  cyc = 0;
    int  n_tests = 0;
    int  n_fail = 0;
    int  mq = 0, md = 0, mn = 0;

    coin_payout #(.GAP(GAP)) dut (
        .clk(clk), .reset(reset), .start(start), .amount(amount),
        .load_inv(load_inv), .inv_q(inv_q), .inv_d(inv_d), .inv_n(inv_n),
        .quarter(quarter), .dime(dime), .nickel(nickel), .busy(busy),
        .done(done), .short(short), .remaining(remaining)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Greedy reference: pushes the coin events and final done for a payout started at edge n0.
    task automatic model_payout(input int n0, input int amt);
        int rem = amt;
        int k = 0;
        ev_t e;
        while (1) begin
            if (rem >= 25 && (!INV || mq > 0)) begin
                e.kind = K_Q; rem -= 25; mq--;
            end else if (rem >= 10 && (!INV || md > 0)) begin
                e.kind = K_D; rem -= 10; md--;
            end else if (rem >= 5 && (!INV || mn > 0)) begin
                e.kind = K_N; rem -= 5; mn--;
            end else break;
            e.cyc = n0 + 1 + k * PER;
            e.rem = 6'(rem);
            e.shrt = 1'b0;
            exp_q.push_back(e);
            k++;
        end
        e.kind = K_DONE;
        e.cyc = n0 + 2 + k * PER;
        e.rem = 6'(rem);
        e.shrt = INV && (rem >= 5);
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        logic [3:0] k;
        ev_t e;
        k = {quarter, dime, nickel, done};
        if (reset && k != 4'b0000) begin
            n_tests++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_output: observed kind %b at cycle %0d expected none", k, cyc);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("event_kind", int'(k), int'(e.kind));
                check("event_cycle", cyc, e.cyc);
                check("event_remaining", int'(remaining), int'(e.rem));
                if (e.kind == K_DONE) check("done_short", int'(short), int'(e.shrt));
            end
        end
    end

    task automatic pay(input int amt, input bit ld, input int q, input int d, input int n,
                       input bit intrude);
        int n0;
        @(negedge clk);
        start = 1'b1;
        amount = 6'(amt);
        load_inv = ld;
        inv_q = 4'(q); inv_d = 4'(d); inv_n = 4'(n);
        if (ld && INV) begin mq = q; md = d; mn = n; end
        n0 = cyc + 1;
        model_payout(n0, amt);
        @(negedge clk);
        start = 1'b0;
        load_inv = 1'b0;
        check("busy_after_start", int'(busy), 1);
        check("short_cleared", int'(short), 0);
        check("remaining_loaded", int'(remaining), amt);
        if (intrude) begin
            repeat (3) @(negedge clk);
            start = 1'b1;
            amount = 6'd10;
            load_inv = 1'b1;
            inv_q = 4'd0; inv_d = 4'd0; inv_n = 4'd0;
            @(negedge clk);
            start = 1'b0;
            load_inv = 1'b0;
        end
    endtask

    task automatic finish_payout(input string tag);
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check({tag, "_events_drained"}, exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk);
        check({tag, "_idle_busy"}, int'(busy), 0);
        check({tag, "_done_low"}, int'(done), 0);
    endtask

    initial begin
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_quarter", int'(quarter), 0);
        check("rst_dime", int'(dime), 0);
        check("rst_nickel", int'(nickel), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_short", int'(short), 0);
        check("rst_remaining", int'(remaining), 0);
        reset = 1'b1;
        @(negedge clk);

        pay(40, 1'b1, 15, 15, 15, 1'b0);
        finish_payout("p40");

        pay(0, 1'b0, 0, 0, 0, 1'b0);
        finish_payout("p0");

        pay(35, 1'b1, 0, 1, 10, 1'b0);
        finish_payout("p35");

        pay(15, 1'b1, 0, 0, 0, 1'b0);
        finish_payout("p15_empty");
        check("short_held", int'(short), INV ? 1 : 0);
        check("remaining_held", int'(remaining), INV ? 15 : 0);

        pay(43, 1'b1, 15, 15, 15, 1'b0);
        finish_payout("p43_residue");
        check("residue_no_short", int'(short), 0);

        pay(63, 1'b1, 15, 15, 15, 1'b0);
        finish_payout("p63");

        pay(40, 1'b1, 15, 15, 15, 1'b1);
        finish_payout("p40_intrude");

        // Abort during the first quarter pulse.
        pay(40, 1'b1, 15, 15, 15, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (quarter) break;
            @(negedge clk);
        end
        check("abort_saw_quarter", int'(quarter), 1);
        reset = 1'b0;
        @(negedge clk);
        exp_q.delete();
        mq = 0; md = 0; mn = 0;
        check("abort_quarter", int'(quarter), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_remaining", int'(remaining), 0);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        check("abort_no_done_busy", int'(busy), 0);

        pay(25, 1'b1, 2, 2, 2, 1'b0);
        finish_payout("p25_after_abort");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
